// File: rtl/reservoir_node_mac.sv
// Reservoir neuron MAC: N_TAPS signed Q1.15 w*s products -> saturated Q2.15 pre-activation, result 2 cycles after last tap.
// Taps are accepted only in ACCUM (tap_ready by state); the result holds in OUT until out_ready, stalling new starts.
module reservoir_node_mac #(
  parameter int N_TAPS = 16,
  parameter int ACC_W  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tap_valid,
  output logic        tap_ready,
  input  logic [15:0] w,
  input  logic [15:0] s,
  output logic [16:0] pre,
  output logic        sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int                      CNT_W    = $clog2(N_TAPS + 1);
  localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] POS_MAX  = ACC_W'(65535);
  localparam logic signed [ACC_W-1:0] NEG_MIN  = ACC_W'(-65536);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic signed [31:0]      r_preg;
  logic                    r_pvalid;
  logic [16:0]             r_pre;
  logic                    r_sat;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_start;
  logic signed [15:0]      w_w_s;
  logic signed [15:0]      w_s_s;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_preg_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic [16:0]             w_pre_nxt;
  logic                    w_sat_nxt;

  assign tap_ready = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign pre       = r_pre;
  assign sat       = r_sat;
  assign out_valid = r_out_valid;

  assign w_accept = tap_ready && tap_valid;
  assign w_last   = w_accept && (r_count == LAST_TAP);
  assign w_start  = (r_state == IDLE) && start;

  // Widening each operand first keeps the full 16x16 signed product exact.
  assign w_w_s  = $signed(w);
  assign w_s_s  = $signed(s);
  assign w_prod = 32'(w_w_s) * 32'(w_s_s);

  assign w_preg_ext = ACC_W'(r_preg);
  assign w_sum      = r_acc + (r_pvalid ? w_preg_ext : '0);
  assign w_shift    = w_sum >>> 15;

  always_comb begin
    w_pre_nxt = w_shift[16:0];
    w_sat_nxt = 1'b0;
    if (w_shift > POS_MAX) begin
      w_pre_nxt = 17'h0FFFF;
      w_sat_nxt = 1'b1;
    end else if (w_shift < NEG_MIN) begin
      w_pre_nxt = 17'h10000;
      w_sat_nxt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACCUM;
      ACCUM:   if (w_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_preg      <= '0;
      r_pvalid    <= 1'b0;
      r_pre       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pvalid <= w_accept;
      if (w_accept) begin
        r_preg  <= w_prod;
        r_count <= r_count + CNT_W'(1);
      end

      // The product lags acceptance by one edge, so DRAIN folds in the last one.
      if (((r_state == ACCUM) || (r_state == DRAIN)) && r_pvalid) begin
        r_acc <= w_sum;
      end

      if (w_start) begin
        r_acc    <= '0;
        r_count  <= '0;
        r_pvalid <= 1'b0;
      end

      if (r_state == DRAIN) begin
        r_pre       <= w_pre_nxt;
        r_sat       <= w_sat_nxt;
        r_out_valid <= 1'b1;
      end else if ((r_state == OUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reservoir_node_mac.sv
// Bench for reservoir_node_mac: a 4-tap and a 2-tap instance share tap inputs; only the started one may react.
module tb_reservoir_node_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4, start2;
  logic        tap_valid, out_ready;
  logic [15:0] w, s;
  logic        tap_ready4, tap_ready2;
  logic [16:0] pre4, pre2;
  logic        sat4, sat2, ov4, ov2, busy4, busy2;

  reservoir_node_mac #(.N_TAPS(4), .ACC_W(48)) u_mac4 (
    .clk(clk), .rst(rst), .start(start4), .tap_valid(tap_valid), .tap_ready(tap_ready4),
    .w(w), .s(s), .pre(pre4), .sat(sat4), .out_valid(ov4), .out_ready(out_ready), .busy(busy4)
  );

  reservoir_node_mac #(.N_TAPS(2), .ACC_W(48)) u_mac2 (
    .clk(clk), .rst(rst), .start(start2), .tap_valid(tap_valid), .tap_ready(tap_ready2),
    .w(w), .s(s), .pre(pre2), .sat(sat2), .out_valid(ov2), .out_ready(out_ready), .busy(busy2)
  );

  logic        sel;
  logic        m_tap_ready, m_ov, m_sat, m_busy;
  logic [16:0] m_pre;
  assign m_tap_ready = sel ? tap_ready2 : tap_ready4;
  assign m_ov        = sel ? ov2 : ov4;
  assign m_sat       = sel ? sat2 : sat4;
  assign m_busy      = sel ? busy2 : busy4;
  assign m_pre       = sel ? pre2 : pre4;

  typedef struct packed {
    logic [16:0] pre;
    logic        sat;
  } res_t;

  res_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] tw[4];
  logic [15:0] ts[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int n);
    longint acc;
    longint q;
    res_t   r;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(tw[i])) * longint'($signed(ts[i]));
    end
    q = acc >>> 15;
    if (q > 65535) begin
      r.pre = 17'h0FFFF; r.sat = 1'b1;
    end else if (q < -65536) begin
      r.pre = 17'h10000; r.sat = 1'b1;
    end else begin
      r.pre = q[16:0];   r.sat = 1'b0;
    end
    return r;
  endfunction

  task automatic set_start(input bit use2, input bit v);
    if (use2) start2 = v; else start4 = v;
  endtask

  task automatic begin_update(input bit use2);
    sel = use2;
    @(posedge clk); #1;
    set_start(use2, 1'b1);
    @(posedge clk); #1;
    set_start(use2, 1'b0);
  endtask

  task automatic feed_taps(input int n, input int gap);
    int to;
    for (int i = 0; i < n; i++) begin
      tap_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      w = tw[i]; s = ts[i]; tap_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!m_tap_ready && to < 20) begin @(negedge clk); to++; end
      if (to >= 20) check_eq("tap_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    tap_valid = 1'b0;
    w = 16'h7FFF; s = 16'h7FFF;
  endtask

  task automatic do_update(input bit use2, input int n, input int gap, input int hold, input bit poke);
    res_t        exp;
    int          to;
    logic [16:0] pre_hold;
    out_ready = (hold == 0);
    begin_update(use2);
    sb.push_back(model(n));
    feed_taps(n, gap);
    to = 1;
    @(negedge clk);
    while (!m_ov && to < 20) begin @(negedge clk); to++; end
    check_eq("latency", to, 2);
    if (sb.size() > 0) exp = sb.pop_front(); else exp = '0;
    check_eq("pre", {15'd0, m_pre}, {15'd0, exp.pre});
    check_eq("sat", {31'd0, m_sat}, {31'd0, exp.sat});
    pre_hold = m_pre;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        set_start(use2, poke && (k == 1));
        @(negedge clk);
        check_eq("hold_vld", {31'd0, m_ov}, 1);
        check_eq("hold_pre", {15'd0, m_pre}, {15'd0, pre_hold});
        check_eq("hold_trdy", {31'd0, m_tap_ready}, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      set_start(use2, poke);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_start(use2, 1'b0);
    @(negedge clk);
    check_eq("release_vld", {31'd0, m_ov}, 0);
    check_eq("release_busy", {31'd0, m_busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0; tap_valid = 1'b0; out_ready = 1'b0;
    w = '0; s = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start4 = 1'b1;
    @(negedge clk);
    check_eq("rst_vld", {31'd0, ov4}, 0);
    check_eq("rst_busy", {31'd0, busy4}, 0);
    check_eq("rst_trdy", {31'd0, tap_ready4}, 0);
    check_eq("rst_pre", {15'd0, pre4}, 0);
    check_eq("rst_sat", {31'd0, sat4}, 0);
    @(posedge clk); #1;
    check_eq("rst_over_start", {31'd0, busy4}, 0);
    rst = 1'b0; start4 = 1'b0;

    tw = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    ts = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    do_update(1'b0, 4, 0, 0, 1'b0);

    tw = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    ts = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    do_update(1'b0, 4, 0, 0, 1'b0);

    tw = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    do_update(1'b0, 4, 0, 0, 1'b0);

    tw = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    ts = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    do_update(1'b1, 2, 0, 0, 1'b0);

    tw = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    do_update(1'b1, 2, 0, 0, 1'b0);
    check_eq("idle_twin_busy", {31'd0, busy4}, 0);
    check_eq("idle_twin_vld", {31'd0, ov4}, 0);

    // Taps offered while idle must not leak into the next update.
    sel = 1'b0;
    w = 16'h7FFF; s = 16'h7FFF; tap_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tap_valid = 1'b0;
    tw = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    ts = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    do_update(1'b0, 4, 3, 4, 1'b1);
    check_eq("stall_twin_busy", {31'd0, busy2}, 0);

    begin_update(1'b0);
    feed_taps(2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'd0, busy4}, 0);
    check_eq("abort_vld", {31'd0, ov4}, 0);
    check_eq("abort_trdy", {31'd0, tap_ready4}, 0);
    check_eq("abort_pre", {15'd0, pre4}, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov4) seen++;
    end
    check_eq("abort_no_out", seen, 0);

    tw = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    ts = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    do_update(1'b0, 4, 0, 0, 1'b0);

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservoir_node_mac.md
RESERVOIR_NODE_MAC -- requirements
Module: reservoir_node_mac

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 16, giving the number of weight/state products per neuron update; the legal range is 2..65536.
REQ-002 The block SHALL have parameter ACC_W, default 48, giving the signed accumulator width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: begins one neuron update when sampled high in IDLE.
REQ-007 Port tap_valid, input, 1 bit: w and s hold a valid tap.
REQ-008 Port tap_ready, output, 1 bit: the block accepts a tap this cycle.
REQ-009 Port w, input, 16 bits: signed Q1.15 weight.
REQ-010 Port s, input, 16 bits: signed Q1.15 reservoir state or input sample.
REQ-011 Port pre, output, 17 bits: signed Q2.15 saturated pre-activation, fed directly to the 17-bit tanh stage.
REQ-012 Port sat, output, 1 bit: set when pre was clipped.
REQ-013 Port out_valid, output, 1 bit: pre and sat are valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts pre.
REQ-015 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, DRAIN and OUT.
REQ-017 IDLE: start=1 SHALL clear the accumulator, the tap count and the product-valid flag, and move to ACCUM; start SHALL be ignored in every other state.
REQ-018 tap_ready SHALL be 1 only in ACCUM and SHALL be combinational on the state only.
REQ-019 A tap SHALL be accepted on each rising edge where tap_valid and tap_ready are both 1; gaps in tap_valid SHALL stall the update without altering the result.
REQ-020 Multiplication SHALL be full signed 16x16 to a 32-bit product, registered into preg with pvalid=1 on acceptance; pvalid SHALL be 0 on any cycle with no acceptance.
REQ-021 Each edge in ACCUM or DRAIN with pvalid=1 SHALL add the sign-extended preg to the accumulator (acc).
REQ-022 Accumulation SHALL use no intermediate rounding or saturation; ACC_W bits SHALL prevent wrap for all legal N_TAPS.
REQ-023 When the N_TAPS-th tap is accepted, the FSM SHALL move to DRAIN.
REQ-024 DRAIN (one cycle): the block SHALL compute acc+preg, shift it arithmetically right by 15 (floor, no rounding), and saturate to [-65536, 65535].
REQ-025 At the end of DRAIN, pre, sat and out_valid=1 SHALL all be registered, and the FSM SHALL move to OUT.
REQ-026 Latency: if the last tap is accepted at the edge ending cycle T, out_valid SHALL first be 1 in cycle T+2.
REQ-027 OUT: pre, sat and out_valid SHALL hold stable until out_ready=1. On that edge, out_valid SHALL go to 0 and the FSM SHALL return to IDLE; a start in that same cycle SHALL be ignored.
REQ-028 On saturation, sat SHALL be 1 with pre=0x0FFFF (positive overflow) or pre=0x10000 (negative overflow); otherwise sat SHALL be 0.
REQ-029 out_valid SHALL never be 1 outside OUT.
REQ-030 tap_valid outside ACCUM SHALL have no effect.

Reset
REQ-031 rst=1 SHALL force, at the next edge and from any state, state=IDLE and acc=0, count=0, preg=0, pvalid=0, pre=0, sat=0 and out_valid=0; consequently tap_ready=0 and busy=0.
REQ-032 rst SHALL take priority over start, tap handshakes and out_ready in the same cycle.
REQ-033 Any partial update in progress SHALL be discarded with no output produced.

Verification
REQ-034 Nominal: N_TAPS=4; 4 taps with w=s=0x4000 (contiguous tap_valid); out_ready=1 -> out_valid rises 2 cycles after the last accept with pre=0x08000 and sat=0.
REQ-035 Saturation: N_TAPS=4; taps w=s=0x7FFF -> pre=0x0FFFF, sat=1. Taps w=0x8000, s=0x7FFF -> pre=0x10000, sat=1.
REQ-036 Truncation: N_TAPS=2; taps (0x0001,0x0001) and (0x0000,0x0000) -> pre=0x00000. Taps (0xFFFF,0x0001) and (0x0000,0x0000) -> pre=0x1FFFF (floor of -1/32768 gives -1 LSB).
REQ-037 Stalls and backpressure: the nominal case with 3-cycle tap_valid gaps between taps and out_ready held low for 5 cycles -> identical pre=0x08000; pre and out_valid held stable; tap_ready=0 throughout OUT; a start pulse during OUT is ignored.
REQ-038 Reset mid-operation: rst for 1 cycle after 2 of 4 taps -> busy=0 and out_valid=0 next cycle; a new start with 4 taps of (0x2000,0x4000) -> pre=0x04000 with no residue from the aborted update.
